// File: rtl/pdm_cic_decim.sv
// rtl/pdm_cic_decim.sv - multi-channel sinc^N CIC decimator for 1-bit PDM streams
// Integrators run every enabled edge; combs, scaling and the valid/ready output run off a one-cycle strobe.
module pdm_cic_decim #(
    parameter int NUM_CH   = 2,
    parameter int ORDER    = 3,
    parameter int DEC_RATE = 64,
    parameter int OUT_W    = 16,
    parameter int ACC_W    = ORDER * $clog2(DEC_RATE) + 2,
    parameter int SHIFT    = (ORDER * $clog2(DEC_RATE) > OUT_W - 1) ?
                             ORDER * $clog2(DEC_RATE) - (OUT_W - 1) : 0
) (
    input  logic                      mclk1,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         mdata,
    output logic [NUM_CH*OUT_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int CW = $clog2(DEC_RATE);
    localparam int FW = $clog2(ORDER + 1);
    localparam int WW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [WW-1:0] SAT_HI = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_LO = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [CW-1:0]             cnt;
    logic                      dec_stb;
    logic                      out_stb;
    logic [FW-1:0]             fill;
    logic                      new_word;
    logic [ACC_W-1:0]          xin     [NUM_CH];
    logic [ACC_W-1:0]          integ   [NUM_CH][ORDER];
    logic [ACC_W-1:0]          comb_z  [NUM_CH][ORDER];
    logic [ACC_W-1:0]          comb_in [NUM_CH][ORDER+1];
    logic signed [ACC_W-1:0]   dlast   [NUM_CH];
    logic signed [ACC_W-1:0]   shv     [NUM_CH];
    logic signed [WW-1:0]      wide    [NUM_CH];
    logic [NUM_CH*OUT_W-1:0]   sat_word;

    // comb_in[c][k] is the input to comb stage k; comb_in[c][ORDER] is the final difference
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            xin[c] = mdata[c] ? ACC_W'(1) : '1;
            comb_in[c][0] = integ[c][ORDER-1];
            for (int k = 0; k < ORDER; k++)
                comb_in[c][k+1] = comb_in[c][k] - comb_z[c][k];
        end
    end

    always_comb begin
        sat_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            shv[c]  = dlast[c] >>> SHIFT;
            wide[c] = {{(WW-ACC_W){shv[c][ACC_W-1]}}, shv[c]};
            if (wide[c] > SAT_HI)
                sat_word[c*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
            else if (wide[c] < SAT_LO)
                sat_word[c*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
            else
                sat_word[c*OUT_W +: OUT_W] = wide[c][OUT_W-1:0];
        end
    end

    // the first ORDER words after a restart are still flushing the comb delays
    assign new_word = out_stb && (fill == FW'(ORDER));

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            cnt <= '0; dec_stb <= 1'b0; out_stb <= 1'b0; fill <= '0;
            out_data <= '0; out_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                dlast[c] <= '0;
                for (int k = 0; k < ORDER; k++) begin
                    integ[c][k]  <= '0;
                    comb_z[c][k] <= '0;
                end
            end
        end else if (!enable) begin
            cnt <= '0; dec_stb <= 1'b0; out_stb <= 1'b0; fill <= '0;
            out_data <= '0; out_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                dlast[c] <= '0;
                for (int k = 0; k < ORDER; k++) begin
                    integ[c][k]  <= '0;
                    comb_z[c][k] <= '0;
                end
            end
        end else begin
            cnt     <= cnt + CW'(1);
            dec_stb <= (cnt == CW'(DEC_RATE - 1));
            out_stb <= dec_stb;
            for (int c = 0; c < NUM_CH; c++) begin
                integ[c][0] <= integ[c][0] + xin[c];
                for (int k = 1; k < ORDER; k++)
                    integ[c][k] <= integ[c][k] + integ[c][k-1];
                if (dec_stb) begin
                    for (int k = 0; k < ORDER; k++)
                        comb_z[c][k] <= comb_in[c][k];
                    dlast[c] <= comb_in[c][ORDER];
                end
            end
            if (out_stb && (fill != FW'(ORDER)))
                fill <= fill + FW'(1);
            if (new_word) begin
                out_data  <= sat_word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset)
            overrun <= 1'b0;
        else if (enable && new_word && out_valid && !out_ready)
            overrun <= 1'b1;
        else if (overrun_clr)
            overrun <= 1'b0;
    end

endmodule
